hdb3_decoder: RTL

Receive-side HDB3 decoder that takes the bipolar rail pair produced by the `hdb3` encoder (`o_p`/`o_n`, one symbol per clock at 2.048 MHz) and recovers the NRZ bit stream. It detects AMI violations, removes the 000V and B00V substitutions, and flags line-code errors. It also maintains a saturating error counter and a loss-of-signal indication. It sits directly downstream of `hdb3`, in loopback in the bench or behind the line receiver in hardware.

---
 rtl/hdb3_pkg.sv | 28 ++
 rtl/hdb3_err_mon.sv | 60 ++++++
 rtl/hdb3_decoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/hdb3_pkg.sv
// Shared types and constants for the HDB3 receive path.
// Symbol classification of the bipolar rail pair lives here so every block agrees on it.
package hdb3_pkg;

    localparam logic POL_POS = 1'b1;
    localparam logic POL_NEG = 1'b0;

    localparam int LOS_ZEROS_DEF = 15;

    typedef enum logic [1:0] {
        SYM_ZERO     = 2'd0,
        SYM_MARK_P   = 2'd1,
        SYM_MARK_N   = 2'd2,
        SYM_CODE_ERR = 2'd3
    } sym_t;

    function automatic sym_t classify(input logic p, input logic n);
        sym_t s;
        case ({p, n})
            2'b10:   s = SYM_MARK_P;
            2'b01:   s = SYM_MARK_N;
            2'b11:   s = SYM_CODE_ERR;
            default: s = SYM_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hdb3_err_mon.sv
// Line-quality monitor: saturating error-cycle counter and zero-run based loss-of-signal.
// Kept apart from the decode datapath; it only sees the registered error pulses and mark strobes.
module hdb3_err_mon
    import hdb3_pkg::*;
#(
    parameter int LOS_ZEROS = LOS_ZEROS_DEF,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_cnt,
    input  logic             err_code,
    input  logic             err_bpv,
    input  logic             is_mark,
    output logic [CNT_W-1:0] err_cnt,
    output logic             los
);

    localparam logic [7:0]       LOS_TH  = 8'(LOS_ZEROS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [7:0]       run_r;
    logic [7:0]       run_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             los_r;

    // Next zero-run length: marks restart the run, anything else extends it up to 255.
    always_comb begin
        run_nxt_s = run_r;
        if (is_mark) begin
            run_nxt_s = 8'd0;
        end else if (run_r != 8'hFF) begin
            run_nxt_s = run_r + 8'd1;
        end else begin
            run_nxt_s = run_r;
        end
    end

    // Counter and LOS state; LOS follows the new run length so a mark clears it on its own edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_r <= 8'd0;
            los_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            run_r <= run_nxt_s;
            los_r <= (run_nxt_s >= LOS_TH);
            if (clr_cnt) begin
                cnt_r <= '0;
            end else if ((err_code || err_bpv) && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign err_cnt = cnt_r;
    assign los     = los_r;

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: classifies rail pairs, detects violations, strips 000V/B00V
// substitutions through a 4-deep bit pipeline and reports code and bipolar-violation errors.
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int LOS_ZEROS = LOS_ZEROS_DEF,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_p,
    input  logic             i_n,
    input  logic             i_clr_cnt,
    output logic             o_data,
    output logic             o_valid,
    output logic             o_err_code,
    output logic             o_err_bpv,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_los
);

    sym_t       sym_s;
    logic       is_mark_s;
    logic       pol_s;
    logic       is_v_s;
    logic       bpv_s;

    logic [3:0] sr_r;
    logic       last_pol_r;
    logic       pol_ok_r;
    logic       last_v_pol_r;
    logic       v_ok_r;
    logic       err_code_r;
    logic       err_bpv_r;
    logic [1:0] fill_cnt_r;
    logic       valid_r;

    assign sym_s = classify(i_p, i_n);

    // Mark/polarity decode and violation qualification for the current symbol.
    always_comb begin
        is_mark_s = 1'b0;
        pol_s     = POL_NEG;
        case (sym_s)
            SYM_MARK_P: begin
                is_mark_s = 1'b1;
                pol_s     = POL_POS;
            end
            SYM_MARK_N: begin
                is_mark_s = 1'b1;
                pol_s     = POL_NEG;
            end
            default: begin
                is_mark_s = 1'b0;
                pol_s     = POL_NEG;
            end
        endcase
        is_v_s = is_mark_s && pol_ok_r && (pol_s == last_pol_r);
        // A legal V has two zeros ahead of it and alternates polarity with the previous V.
        bpv_s  = is_v_s && (sr_r[0] || sr_r[1] || (v_ok_r && (pol_s == last_v_pol_r)));
    end

    // Decode pipeline, polarity history, error pulses and output-valid fill tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sr_r         <= 4'b0000;
            last_pol_r   <= POL_NEG;
            pol_ok_r     <= 1'b0;
            last_v_pol_r <= POL_NEG;
            v_ok_r       <= 1'b0;
            err_code_r   <= 1'b0;
            err_bpv_r    <= 1'b0;
            fill_cnt_r   <= 2'd0;
            valid_r      <= 1'b0;
        end else begin
            // On a V the oldest stage is zeroed, which removes the B of a B00V.
            sr_r <= {(is_v_s ? 1'b0 : sr_r[2]), sr_r[1], sr_r[0], (is_mark_s && !is_v_s)};
            if (is_mark_s) begin
                last_pol_r <= pol_s;
                pol_ok_r   <= 1'b1;
            end
            if (is_v_s) begin
                last_v_pol_r <= pol_s;
                v_ok_r       <= 1'b1;
            end
            err_code_r <= (sym_s == SYM_CODE_ERR);
            err_bpv_r  <= bpv_s;
            if (!valid_r) begin
                fill_cnt_r <= fill_cnt_r + 2'd1;
                if (fill_cnt_r == 2'd3) begin
                    valid_r <= 1'b1;
                end
            end
        end
    end

    hdb3_err_mon #(
        .LOS_ZEROS (LOS_ZEROS),
        .CNT_W     (CNT_W)
    ) u_err_mon (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr_cnt  (i_clr_cnt),
        .err_code (err_code_r),
        .err_bpv  (err_bpv_r),
        .is_mark  (is_mark_s),
        .err_cnt  (o_err_cnt),
        .los      (o_los)
    );

    assign o_data     = sr_r[3];
    assign o_valid    = valid_r;
    assign o_err_code = err_code_r;
    assign o_err_bpv  = err_bpv_r;

endmodule
